// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction field slices, bubble/NOP words,
// branch-bus layout and the flush FSM state type.
package pipeline_pkg;

    localparam int INSTR_OPC_HI  = 11;
    localparam int INSTR_OPC_LO  = 8;
    localparam int INSTR_SRC1_HI = 15;
    localparam int INSTR_SRC1_LO = 12;
    localparam int INSTR_SRC2_HI = 19;
    localparam int INSTR_SRC2_LO = 16;

    localparam logic [23:0]  NOP_INSTR   = 24'h000800;
    localparam int           OFEX_W      = 157;
    localparam logic [156:0] OFEX_BUBBLE = '0;

    localparam logic [3:0] OPC_FLAGREAD = 4'b1011;
    localparam logic [3:0] FLAG_REG     = 4'd15;

    localparam int BR_TAKEN  = 8;
    localparam int BR_TGT_HI = 7;
    localparam int BR_TGT_LO = 0;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } flush_state_e;

endpackage

// File: rtl/hazard_controller_if.sv
// Operand-fetch side bundle of the hazard controller: decoded IF/OF state and
// branch bus in, stall/flush/redirect controls and perf counters out.
interface hazard_controller_if;
    logic [23:0] id_instr;
    logic        id_valid;
    logic        id_wr_en;
    logic [3:0]  id_wr_addr;
    logic [8:0]  ex_branch;

    logic        hold_if;
    logic        bubble_ex;
    logic        flush_if;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;

    modport master (
        output id_instr, id_valid, id_wr_en, id_wr_addr, ex_branch,
        input  hold_if, bubble_ex, flush_if, pc_load, pc_target,
               stall_cycles, flush_events
    );

    modport slave (
        input  id_instr, id_valid, id_wr_en, id_wr_addr, ex_branch,
        output hold_if, bubble_ex, flush_if, pc_load, pc_target,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write tracker: each entry counts down the cycles
// until its pending RW write becomes visible to operand fetch.
module hazard_scoreboard #(
    parameter int WB_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue,
    input  logic [3:0]  issue_addr,
    output logic [15:0] busy
);
    localparam logic [1:0] WB_LOAD = 2'(WB_DEPTH);

    logic [1:0] remaining [16];

    // NOTE: this small counter array must be reset, unlike a data RAM;
    // stale nonzero entries would cause phantom stalls after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) remaining[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (issue && issue_addr == 4'(i))
                    remaining[i] <= WB_LOAD;
                else if (remaining[i] != 2'd0)
                    remaining[i] <= remaining[i] - 2'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) busy[i] = (remaining[i] != 2'd0);
    end
endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer: scoreboard-driven data stalls plus a squash FSM
// that redirects the PC after a taken branch.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int WB_DEPTH     = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                clk,
    input logic                rst_n,
    hazard_controller_if.slave bus
);
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    flush_state_e state, state_next;
    logic [1:0]   fcnt, fcnt_next;
    logic [15:0]  busy;
    logic [3:0]   opc, src1, src2;
    logic         rd_src1, rd_src2, rd_flag, hazard, taken;
    logic         hold, bubble, flush, pc_load, issue;
    logic [15:0]  stall_count, flush_count;
    logic         unused_fields;

    assign opc   = bus.id_instr[INSTR_OPC_HI:INSTR_OPC_LO];
    assign src1  = bus.id_instr[INSTR_SRC1_HI:INSTR_SRC1_LO];
    assign src2  = bus.id_instr[INSTR_SRC2_HI:INSTR_SRC2_LO];
    assign taken = bus.ex_branch[BR_TAKEN];
    assign unused_fields = ^{bus.id_instr[23:20], bus.id_instr[7:0]};

    assign rd_src1 = !opc[3] || (opc[1:0] == 2'b10);
    assign rd_src2 = !opc[3] && (opc[1:0] != 2'b11);
    assign rd_flag = (opc == OPC_FLAGREAD);
    assign hazard  = bus.id_valid && ((rd_src1 && busy[src1]) ||
                                      (rd_src2 && busy[src2]) ||
                                      (rd_flag && busy[FLAG_REG]));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    // Outputs are also forced low while rst_n is asserted, even with a branch pending.
    always_comb begin
        hold       = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        pc_load    = 1'b0;
        state_next = state;
        fcnt_next  = fcnt;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (taken) begin
                        pc_load = 1'b1;
                        flush   = 1'b1;
                        bubble  = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_next = ST_FLUSH;
                            fcnt_next  = FLUSH_LOAD;
                        end
                    end else if (hazard) begin
                        hold   = 1'b1;
                        bubble = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush  = 1'b1;
                    bubble = 1'b1;
                    if (fcnt <= 2'd1) begin
                        state_next = ST_IDLE;
                        fcnt_next  = '0;
                    end else begin
                        fcnt_next = fcnt - 2'd1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign issue = (state == ST_IDLE) && !taken && !hold &&
                   bus.id_valid && bus.id_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            fcnt        <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
            if (hold && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
            if (pc_load && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
        end
    end

    hazard_scoreboard #(.WB_DEPTH(WB_DEPTH)) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .issue_addr(bus.id_wr_addr),
        .busy      (busy)
    );

    assign bus.hold_if      = hold;
    assign bus.bubble_ex    = bubble;
    assign bus.flush_if     = flush;
    assign bus.pc_load      = pc_load;
    assign bus.pc_target    = pc_load ? bus.ex_branch[BR_TGT_HI:BR_TGT_LO] : 8'h00;
    assign bus.stall_cycles = stall_count;
    assign bus.flush_events = flush_count;
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage IF/OF/EX/MA/RW pipeline.
- Replaces the ad-hoc compare logic on the stage registers with two parts:
  - a per-register scoreboard of in-flight writes, which drives data stalls;
  - a flush FSM that squashes the IF/OF and OF/EX registers and redirects the PC after a taken branch.
- Sits beside operand_fetch. Its outputs drive the IF/OF hold, the OF/EX bubble insertion and the instruction_fetch PC load.

Parameters:
- WB_DEPTH, 3, cycles from OF/EX issue until the RW write is visible to operand fetch. Range 1..3.
- FLUSH_CYCLES, 2, cycles of squash after a taken branch. Range 1..3.
- NOP_INSTR, 24'h000800, instruction word injected into IF/OF during a flush.

Ports:
- clk  in  1  pipeline clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- id_instr  in  24  current IF/OF word: [11:8] opcode, [15:12] src1, [19:16] src2
- id_valid  in  1  IF/OF holds a real instruction (not a NOP)
- id_wr_en  in  1  IF/OF instruction writes a register (decoded isWrite)
- id_wr_addr  in  4  destination register; 15 is the flag register
- ex_branch  in  9  [8] taken, [7:0] target PC, from the ALU branch output
- hold_if  out  1  freeze PC and IF/OF this cycle
- bubble_ex  out  1  load the bubble word into OF/EX instead of the OF output
- flush_if  out  1  load NOP_INSTR into IF/OF
- pc_load  out  1  one-cycle PC redirect strobe
- pc_target  out  8  redirect PC, valid while pc_load=1
- stall_cycles  out  16  saturating count of data-stall cycles
- flush_events  out  16  saturating count of taken-branch flushes

Behaviour:

Reset (rst_n low, asynchronous):
- All scoreboard counters cleared to 0; FSM goes to IDLE.
- All outputs 0; both perf counters 0.
- Reset asserted mid-flush abandons the flush immediately. No pc_load is issued after release.

Source decode, combinational from the opcode:
- opcode[3]=0: reads src1. Also reads src2 unless opcode[1:0]=2'b11.
- opcode[3]=1 with opcode[1:0]=2'b10: reads src1.
- opcode=4'b1011: reads register 15.
- All other opcodes read nothing.

Scoreboard:
- 16 entries, each a 2-bit remaining-cycles counter.
- Every cycle, each nonzero counter decrements by 1.
- Issue condition: id_valid & id_wr_en & !hold_if & !ex_branch[8] & state==IDLE. On issue, counter[id_wr_addr] <= WB_DEPTH.
- If an issue and a decrement hit the same entry in one cycle, the issue wins.
- Data hazard: id_valid, and any source actually read has counter != 0.

Data stall (combinational, zero latency from the scoreboard state and id_*):
- On a data hazard while state is IDLE: hold_if=1 and bubble_ex=1.
- stall_cycles increments by 1 on each such cycle, saturating at 16'hFFFF.

Flush FSM, states IDLE and FLUSH, with a 2-bit down-counter:
- IDLE with ex_branch[8]=1:
  - pc_load=1 and pc_target=ex_branch[7:0], combinational in that cycle;
  - flush_if=1 and bubble_ex=1;
  - hold_if forced 0;
  - the issue is suppressed;
  - flush_events increments (saturating);
  - next state: FLUSH with counter=FLUSH_CYCLES-1, or stay IDLE if FLUSH_CYCLES=1.
- FLUSH:
  - flush_if=1, bubble_ex=1, hold_if=0, pc_load=0;
  - the counter decrements each cycle; at 0 the FSM returns to IDLE;
  - ex_branch[8] is ignored, because only bubbles can occupy EX;
  - no issue and no stall counting.
- Branch and data hazard in the same cycle: the flush takes priority. hold_if=0 and stall_cycles does not increment.

Other boundaries:
- The scoreboard keeps decrementing during FLUSH, so older writes still retire.
- Back-to-back writes to one register re-arm that entry to WB_DEPTH.
- A write to register 15 followed by opcode 1011 stalls until counter[15]=0.
- Register 0 is tracked like any other register.

Decomposition:
- Shared package pipeline_pkg holds:
  - the field slices INSTR_OPC, INSTR_SRC1, INSTR_SRC2;
  - NOP_INSTR and the 157-bit OF/EX bubble constant;
  - the opcode constant OPC_FLAGREAD=4'b1011;
  - the branch-bus bit indices;
  - the FSM state enum.
- One sub-module, hazard_scoreboard, holds the 16 counters, the issue/decrement logic and the busy[15:0] output. The FSM, source decode and perf counters stay in the top level.

Test Plan:
1. Reset release, then issue a write to r3 (opcode 0000), then an instruction reading src1=3 in the next cycle → hold_if=1 and bubble_ex=1 for exactly 3 cycles (WB_DEPTH=3), release in the 4th; stall_cycles=3.
2. Taken branch ex_branch=9'h1_2A with the FSM in IDLE → pc_load=1 and pc_target=8'h2A for 1 cycle; flush_if=1 and bubble_ex=1 for 2 cycles; flush_events=1.
3. Branch together with a data hazard on r5 in the same cycle → hold_if=0, flush wins; the r5 counter keeps decrementing; stall_cycles unchanged.
4. Write r15, then opcode 1011 with src fields that do not match → stall of 3 cycles. Opcode 1000 reading nothing while r15 is busy → no stall.
5. Two consecutive writes to r7, then a read of r7 → the stall lasts until 3 cycles after the second write's issue.
6. Assert rst_n low during FLUSH cycle 1 → all outputs 0 immediately; after release, FSM in IDLE, no pc_load, scoreboard empty (a read of any register gives no stall).
